// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch requester (IF)
//   and the load/store requester (D). Both requesters use a req/done handshake.
//   The memory side uses a req/ready handshake with variable latency. A
//   saturating timeout counter aborts a transaction if the memory never
//   answers.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  max cycles m_req may stay high without m_ready before abort (>=1)
//
// Ports
//   clk, rst_n                   rising-edge clock, asynchronous active-low reset
//   if_req, if_addr              fetch request, held stable until if_done
//   if_rdata, if_done, if_err    fetch result, one-cycle done pulse, timeout flag
//   d_req, d_addr, d_we, d_op,   data request, held stable until d_done
//   d_wdata
//   d_rdata, d_done, d_err       load result (0 for stores), done pulse, timeout flag
//   m_req, m_addr, m_we, m_op,   memory request, held constant while busy
//   m_wdata
//   m_ready, m_rdata             memory completion, read data valid with m_ready
//   grant                        one-hot owner: 01 = IF, 10 = D, 00 = none
//
// Timing: request seen at edge 0 -> m_req high in cycle 1; m_ready in cycle 1
// -> done in cycle 2; back in IDLE in cycle 3.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [2:0]        d_op,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,

    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [2:0]        m_op,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,

    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // Instruction fetches are always full-word loads.
    localparam logic [2:0] OP_WORD = 3'b010;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [1:0]       state;
    logic             last_d;   // 1 = D owned the port last, 0 = IF
    logic [CNT_W-1:0] cnt;
    logic             d_wins;
    logic             expire;

    // Saturating increment: the wait counter sticks at TIMEOUT, never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Round-robin: on a conflict the requester that did not go last wins.
    // last_d resets to 0 (IF) so D takes the first conflict.
    assign d_wins = d_req && (!if_req || !last_d);

    // This idle cycle would push the counter to TIMEOUT, so the current
    // cycle is the last one the memory gets to answer in.
    assign expire = (sat_inc(cnt) == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            cnt      <= '0;
            grant    <= GNT_NONE;
            m_req    <= 1'b0;
            m_addr   <= '0;
            m_we     <= 1'b0;
            m_op     <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            if_done  <= 1'b0;
            if_err   <= 1'b0;
            d_rdata  <= '0;
            d_done   <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            case (state)
                // Stage: arbitrate and launch the memory request
                IDLE: begin
                    if (d_wins) begin
                        state   <= BUSY_D;
                        grant   <= GNT_D;
                        m_req   <= 1'b1;
                        m_addr  <= d_addr;
                        m_we    <= d_we;
                        m_op    <= d_op;
                        m_wdata <= d_wdata;
                        last_d  <= 1'b1;
                        cnt     <= '0;
                    end else if (if_req) begin
                        state   <= BUSY_I;
                        grant   <= GNT_I;
                        m_req   <= 1'b1;
                        m_addr  <= if_addr;
                        m_we    <= 1'b0;
                        m_op    <= OP_WORD;
                        m_wdata <= '0;
                        last_d  <= 1'b0;
                        cnt     <= '0;
                    end
                end

                // Stage: wait for memory; m_ready beats a same-edge timeout
                BUSY_I, BUSY_D: begin
                    if (m_ready) begin
                        state <= RESP;
                        m_req <= 1'b0;
                        if (state == BUSY_I) begin
                            if_rdata <= m_rdata;
                            if_done  <= 1'b1;
                            if_err   <= 1'b0;
                        end else begin
                            d_rdata <= m_we ? '0 : m_rdata;
                            d_done  <= 1'b1;
                            d_err   <= 1'b0;
                        end
                    end else if (expire) begin
                        state <= RESP;
                        m_req <= 1'b0;
                        cnt   <= CNT_MAX;
                        if (state == BUSY_I) begin
                            if_rdata <= '0;
                            if_done  <= 1'b1;
                            if_err   <= 1'b1;
                        end else begin
                            d_rdata <= '0;
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end

                // Stage: done pulse visible for exactly this cycle
                RESP: begin
                    state   <= IDLE;
                    grant   <= GNT_NONE;
                    if_done <= 1'b0;
                    if_err  <= 1'b0;
                    d_done  <= 1'b0;
                    d_err   <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_err;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [2:0]        d_op;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_err;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [2:0]        m_op;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        grant;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_rdata(if_rdata),
        .if_done (if_done),
        .if_err  (if_err),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_we    (d_we),
        .d_op    (d_op),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_we    (m_we),
        .m_op    (m_op),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .grant   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  who;   // 01 = IF, 10 = D
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] who, input logic [31:0] data, input logic err);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a done pulse, then compare it against the scoreboard head.
    task automatic wait_done(input string tag, input int bound);
        int   n;
        exp_t e;
        n = 0;
        while (!(if_done || d_done) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(if_done | d_done), 64'(1));
        if (!(if_done || d_done)) return;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_who"}, 64'({d_done, if_done}), 64'(e.who));
        chk({tag, "_grant"}, 64'({grant, m_req}), 64'({e.who, 1'b0}));
        if (e.who == 2'b01)
            chk({tag, "_if_resp"}, 64'({if_err, if_rdata}), 64'({e.err, e.data}));
        else
            chk({tag, "_d_resp"}, 64'({d_err, d_rdata}), 64'({e.err, e.data}));
    endtask

    initial begin
        logic [1:0]  exp_who;
        logic [31:0] val;

        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_we    = 1'b0;
        d_op    = 3'b010;
        d_wdata = '0;
        m_ready = 1'b0;
        m_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({m_req, grant, if_done, d_done, if_err, d_err}), 64'(0));
        chk("rst_data", 64'({m_addr, m_we, m_op}), 64'(0));
        rst_n = 1'b1;

        // Single IF fetch, memory answers in the first busy cycle
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        chk("if_req_out", 64'({m_req, grant}), 64'({1'b1, 2'b01}));
        chk("if_m_addr", 64'(m_addr), 64'(32'h100));
        chk("if_m_we_op", 64'({m_we, m_op}), 64'({1'b0, 3'b010}));
        push(2'b01, 32'hDEADBEEF, 1'b0);
        m_ready = 1'b1;
        m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        m_ready = 1'b0;
        m_rdata = '0;
        wait_done("if1", 0);
        if_req = 1'b0;
        @(negedge clk);
        chk("if1_after", 64'({if_done, grant, m_req}), 64'(0));
        chk("if1_rdata_hold", 64'(if_rdata), 64'(32'hDEADBEEF));

        // Conflict right after reset: D first, then alternating while both held
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h300;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h400;
        exp_who = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", 64'(grant), 64'(exp_who));
            chk("rr_addr", 64'(m_addr), 64'((exp_who == 2'b10) ? 32'h400 : 32'h300));
            val = 32'hA000_0000 + 32'(k);
            push(exp_who, val, 1'b0);
            m_ready = 1'b1;
            m_rdata = val;
            @(negedge clk);
            m_ready = 1'b0;
            m_rdata = '0;
            wait_done("rr", 0);
            if (k == 3) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            @(negedge clk);
            chk("rr_idle", 64'({grant, if_done, d_done}), 64'(0));
            @(negedge clk);
            exp_who = (exp_who == 2'b10) ? 2'b01 : 2'b10;
        end

        // Store with memory ready on the fifth busy cycle
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'h12345678;
        d_op    = 3'b010;
        @(negedge clk);
        push(2'b10, 32'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            chk("st_hold", 64'({m_req, m_we, m_wdata}), 64'({1'b1, 1'b1, 32'h12345678}));
            chk("st_addr", 64'({m_addr, m_op, d_done}), 64'({32'h20, 3'b010, 1'b0}));
            if (i == 5) begin
                m_ready = 1'b1;
                m_rdata = 32'h5555AAAA;
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        m_rdata = '0;
        wait_done("st", 0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        chk("st_single_pulse", 64'({d_done, grant}), 64'(0));

        // Timeout: memory never answers
        d_req  = 1'b1;
        d_addr = 32'h40;
        @(negedge clk);
        push(2'b10, 32'h0, 1'b1);
        for (int i = 1; i <= TIMEOUT; i++) begin
            chk("to_busy", 64'({m_req, d_done}), 64'({1'b1, 1'b0}));
            @(negedge clk);
        end
        wait_done("to", 0);
        d_req = 1'b0;
        @(negedge clk);
        chk("to_idle", 64'({grant, m_req, d_done, d_err}), 64'(0));

        // Memory answers on the very last allowed cycle: success wins
        d_req  = 1'b1;
        d_addr = 32'h44;
        @(negedge clk);
        push(2'b10, 32'hCAFEF00D, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            chk("edge_busy", 64'({m_req, d_done}), 64'({1'b1, 1'b0}));
            if (i == TIMEOUT) begin
                m_ready = 1'b1;
                m_rdata = 32'hCAFEF00D;
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        m_rdata = '0;
        wait_done("edge", 0);
        d_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of an IF transaction
        if_req  = 1'b1;
        if_addr = 32'h200;
        @(negedge clk);
        chk("ar_busy", 64'({m_req, grant}), 64'({1'b1, 2'b01}));
        d_req  = 1'b1;
        d_addr = 32'h600;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_immediate", 64'({m_req, grant, if_done, d_done}), 64'(0));
        @(negedge clk);
        chk("ar_held", 64'({m_req, grant, if_done, d_done}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_d_first", 64'({grant, m_addr}), 64'({2'b10, 32'h600}));
        push(2'b10, 32'h0BADF00D, 1'b0);
        m_ready = 1'b1;
        m_rdata = 32'h0BADF00D;
        @(negedge clk);
        m_ready = 1'b0;
        m_rdata = '0;
        wait_done("ar", 0);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // m_ready pulsed while idle is ignored
        m_ready = 1'b1;
        m_rdata = 32'hFFFF0000;
        @(negedge clk);
        m_ready = 1'b0;
        m_rdata = '0;
        chk("idle_ready", 64'({if_done, d_done, grant, m_req}), 64'(0));
        @(negedge clk);
        chk("idle_ready2", 64'({if_done, d_done, grant, m_req}), 64'(0));

        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
